// File: rtl/qos_wrr_sched_pkg.sv
// qos_wrr_sched shared types and constants.
// State encoding, sizing, and head-word destination field helper.
package qos_pkg;

  localparam int NUM_Q    = 4;
  localparam int DATA_W   = 12;
  localparam int WEIGHT_W = 3;
  localparam int DEST_MSB = 11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [1:0] destOf(
    input logic [DATA_W-1:0] word
  );
    return word[DEST_MSB:DEST_MSB-1];
  endfunction

endpackage

// File: rtl/qos_wrr_sched_if.sv
// Class-queue and destination-FIFO signal bundle.
// master = scheduler side, slave = FIFO side.
interface qos_wrr_sched_if
  import qos_pkg::*;
();

  logic [NUM_Q-1:0]        q_empty;
  logic [NUM_Q*DATA_W-1:0] q_head;
  logic [NUM_Q-1:0]        pop;
  logic [NUM_Q-1:0]        dst_almost_full;
  logic [NUM_Q-1:0]        push;
  logic [DATA_W-1:0]       data_out;

  modport master (
    input  q_empty,
    input  q_head,
    input  dst_almost_full,
    output pop,
    output push,
    output data_out
  );

  modport slave (
    output q_empty,
    output q_head,
    output dst_almost_full,
    input  pop,
    input  push,
    input  data_out
  );

endinterface

// File: rtl/qos_wrr_sched_rr_pick4.sv
// Rotating-priority finder over four requesters.
// Searches start+1, start+2, start+3, then start itself.
module rr_pick4 (
  input  logic [3:0] elig,
  input  logic [1:0] start,
  output logic       found,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Walk farthest-first so the nearest hit is the last write.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int k = 4; k >= 1; k--) begin
      cand = start + 2'(k);
      if (elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/qos_wrr_sched.sv
// Weighted round-robin scheduler across four class FIFOs.
// Pops one eligible class per cycle, pushes the word a cycle later.
module qos_wrr_sched
  import qos_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      active,
  input  logic                      cfg_load,
  input  logic [NUM_Q*WEIGHT_W-1:0] weights,
  qos_wrr_sched_if.master           qi,
  output logic [1:0]                grant_id,
  output logic                      busy
);

  state_t state;
  state_t nextState;

  logic [WEIGHT_W-1:0] wReg [NUM_Q];
  logic [1:0]          ptr;
  logic [WEIGHT_W-1:0] credit;

  logic [NUM_Q-1:0]  elig;
  logic              arbEn;
  logic              stay;
  logic              pickFound;
  logic [1:0]        pickIdx;
  logic              grantVld;
  logic [1:0]        grantIdx;
  logic [DATA_W-1:0] grantHead;

  logic [NUM_Q-1:0]  pushR;
  logic [DATA_W-1:0] dataR;
  logic [1:0]        gidR;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (active)  nextState = RUN;
      RUN:  if (!active) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN);
    arbEn = (state == RUN) && active;
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      elig[i] = !qi.q_empty[i]
        && (wReg[i] != '0)
        && !qi.dst_almost_full[
             destOf(qi.q_head[i*DATA_W +: DATA_W])];
    end
  end

  rr_pick4 u_pick (
    .elig  (elig),
    .start (ptr),
    .found (pickFound),
    .idx   (pickIdx)
  );

  // Current class keeps the grant while it has credit left.
  always_comb begin
    stay      = elig[ptr] && (credit != '0);
    grantVld  = arbEn && (stay || pickFound);
    grantIdx  = stay ? ptr : pickIdx;
    grantHead = qi.q_head[grantIdx*DATA_W +: DATA_W];
    qi.pop    = grantVld
      ? (NUM_Q'(1) << grantIdx) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      credit <= '0;
      pushR  <= '0;
      dataR  <= '0;
      gidR   <= '0;
      for (int i = 0; i < NUM_Q; i++) wReg[i] <= '1;
    end else begin
      pushR <= '0;
      if (grantVld) begin
        pushR <= NUM_Q'(1) << destOf(grantHead);
        dataR <= grantHead;
        gidR  <= grantIdx;
      end
      if (state == IDLE) begin
        credit <= '0;
        if (cfg_load) begin
          for (int i = 0; i < NUM_Q; i++)
            wReg[i] <= weights[i*WEIGHT_W +: WEIGHT_W];
        end
      end else if (grantVld) begin
        if (stay) begin
          credit <= credit - WEIGHT_W'(1);
        end else begin
          ptr    <= pickIdx;
          credit <= wReg[pickIdx] - WEIGHT_W'(1);
        end
      end
    end
  end

  assign qi.push     = pushR;
  assign qi.data_out = dataR;
  assign grant_id    = gidR;

endmodule

// File: doc/qos_wrr_sched.md
Name: qos_wrr_sched

Overview:
- Weighted round-robin scheduler for the four class FIFOs that sit between the input demux and the shared output FIFO path.
- Each cycle it selects at most one non-empty class queue whose head packet's destination FIFO is not almost-full, and pops that queue.
- It registers the popped word and pushes it into the destination output FIFO one cycle later.
- It replaces fixed-priority arbitration with programmable per-class weights and is gated by the FSM ACTIVE signal.

Parameters:
- NUM_Q, 4, number of class queues and of destination FIFOs (fixed at 4; pointer is 2 bits).
- DATA_W, 12, packet word width.
- WEIGHT_W, 3, width of each per-class weight (0..7).
- DEST_MSB, 11, MSB of the 2-bit destination field in the head word (field is [DEST_MSB:DEST_MSB-1]).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- active  in  1  scheduling enable from FSM
- cfg_load  in  1  latch weights; honoured only in IDLE
- weights  in  4*WEIGHT_W  weight for class i in bits [i*WEIGHT_W +: WEIGHT_W]
- q_empty  in  4  empty flags of the class FIFOs
- q_head  in  4*DATA_W  show-ahead head words of the class FIFOs; class i in bits [i*DATA_W +: DATA_W]
- dst_almost_full  in  4  almost-full flags of the destination FIFOs
- pop  out  4  one-hot pop to the class FIFOs (combinational, same cycle as grant)
- push  out  4  one-hot push to the destination FIFOs (registered)
- data_out  out  DATA_W  registered word driven with push
- grant_id  out  2  class granted in the previous cycle (registered)
- busy  out  1  high in RUN

Behaviour:
- Reset values:
  - pop, push, data_out, grant_id, busy all 0.
  - ptr=0, credit=0, state=IDLE.
  - Weight registers reset to all 1s.
- States:
  - IDLE: no pops. cfg_load=1 latches weights. active=1 moves to RUN on the next cycle with ptr unchanged and credit=0.
  - RUN: arbitrate every cycle. active=0 moves to IDLE on the next cycle; no pop is issued in the cycle active is sampled low. An in-flight push still completes.
- Eligibility: class i is eligible when q_empty[i]=0, weight[i]!=0, and dst_almost_full[d]=0, where d = q_head[i][DEST_MSB:DEST_MSB-1].
- Grant, combinational in RUN:
  - If ptr is eligible and credit>0: grant ptr; credit <= credit-1.
  - Else take the first eligible j in the order ptr+1, ptr+2, ptr+3, ptr (mod 4): grant j; ptr <= j; credit <= weight[j]-1.
  - If no class is eligible: no grant; ptr and credit hold.
- Latency:
  - pop[g] is asserted in cycle N.
  - In cycle N+1: push[d] asserted, data_out = head word sampled in cycle N, grant_id = g.
  - push is 0 in any cycle following a no-grant cycle.
- Throughput: one word per cycle maximum.
- Fairness:
  - A class with weight w receives at most w consecutive grants while another class is eligible.
  - A sole eligible class receives grants every cycle; on wrap the credit reloads.
- Backpressure: almost_full thresholds must leave at least 1 entry of slack for the registered in-flight push. The scheduler does not reserve space itself.
- Simultaneous events:
  - cfg_load in RUN is ignored.
  - reset overrides everything, including an in-flight push; push is 0 in the cycle after reset.
- Weight 0 masks the class permanently until reconfigured.

Decomposition:
- Shared package qos_pkg:
  - state encoding (IDLE=1'b0, RUN=1'b1)
  - NUM_Q, DATA_W, WEIGHT_W
  - the dest-field slice function
- One sub-module, rr_pick4: combinational rotate-priority finder. Inputs are a 4-bit eligible vector and a 2-bit start pointer. Outputs are found and a 2-bit index, searching from start+1 and wrapping to start.

Test Plan:
- Reset, then weights=1,1,1,1, all queues non-empty, all dest 0, no almost_full, active=1 -> grants 1,2,3,0,1,… with one pop per cycle; push[0] follows each pop by exactly 1 cycle with matching data.
- weights={q0=3,q1=1,q2=0,q3=2}, all queues full -> repeating grant pattern 0,0,0,1,3,3; q2 is never popped.
- Only q2 non-empty, weight 2 -> pop[2] asserted every cycle; credit reloads without gaps.
- q0 head dest=1 with dst_almost_full[1]=1, q1 eligible -> q1 granted and q0 skipped; when almost_full[1] drops, q0 is granted within 1 cycle after q1's credit expires.
- active drops mid-stream -> no pop in that cycle, last push still appears next cycle, busy=0; cfg_load in RUN has no effect, takes effect in IDLE.
- reset asserted in the same cycle as a grant -> the next cycle shows push=0, ptr=0, and arbitration restarts from class 1 after re-activation.
